// File: rtl/mod_test_pkg.sv
// Shared definitions for the mod_test board wrapper.
//   SEG_BLANK  : active-low 7-segment pattern with every segment off
//   HB_BITS    : width of the LED heartbeat counter
//   hex_to_seg : nibble to active-low 7-segment pattern, index 0 = segment a
package mod_test_pkg;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam int         HB_BITS   = 24;

  // Patterns are written in segment order a..g, which lines up with the
  // ascending [0:6] range so literal bit 0 (leftmost) lands on segment a.
  function automatic logic [0:6] hex_to_seg(input logic [3:0] nib);
    logic [0:6] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mod_test_mux2x1.sv
// Width-parameterised 2:1 multiplexer, purely combinational.
//   a   : operand selected when sel = 0
//   b   : operand selected when sel = 1
//   sel : select
//   y   : result
module mux2x1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mod_test.sv
// DE2-style board wrapper around a 2:1 mux.
//   CLOCK_50          : system clock
//   KEY[0]            : asynchronous active-low reset; KEY[3:1] unused
//   SW[7:0]/SW[15:8]  : mux operands A/B, SW[17] select
//   LEDR              : combinational mux result [7:0], select echo [17]
//   LEDG              : registered result [7:0], heartbeat [8]
//   HEX0..HEX7        : active-low 7-segment digits of registered values
//   w_d0x*/w_d1x*     : registered debug display buses
//   UART_TXD          : held idle high; GPIO_0/GPIO_1 left floating
module mod_test
  import mod_test_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  input  logic        CLOCK_27,
  input  logic [17:0] SW,
  output logic [0:6]  HEX0,
  output logic [0:6]  HEX1,
  output logic [0:6]  HEX2,
  output logic [0:6]  HEX3,
  output logic [0:6]  HEX4,
  output logic [0:6]  HEX5,
  output logic [0:6]  HEX6,
  output logic [0:6]  HEX7,
  output logic [8:0]  LEDG,
  output logic [17:0] LEDR,
  output logic        UART_TXD,
  input  logic        UART_RXD,
  output logic [7:0]  w_d0x0,
  output logic [7:0]  w_d0x1,
  output logic [7:0]  w_d0x2,
  output logic [7:0]  w_d0x3,
  output logic [7:0]  w_d0x4,
  output logic [7:0]  w_d0x5,
  output logic [7:0]  w_d1x0,
  output logic [7:0]  w_d1x1,
  output logic [7:0]  w_d1x2,
  output logic [7:0]  w_d1x3,
  output logic [7:0]  w_d1x4,
  output logic [7:0]  w_d1x5,
  inout  wire  [35:0] GPIO_0,
  inout  wire  [35:0] GPIO_1
);

  logic               rst_n;
  logic               sel;
  logic [WIDTH-1:0]   mux_y;
  logic [WIDTH-1:0]   r_mux;
  logic [15:0]        sw_p1;
  logic               sel_p1;
  logic [HB_BITS-1:0] hb_cnt;
  logic               hb;
  logic [7:0]         mux_byte;
  logic               unused_inputs;

  assign rst_n = KEY[0];
  assign sel   = SW[17];

  mux2x1 #(.WIDTH(WIDTH)) u_mux (
    .a   (SW[WIDTH-1:0]),
    .b   (SW[2*WIDTH-1:WIDTH]),
    .sel (sel),
    .y   (mux_y)
  );

  // Combinational path: must work with no clock and while reset is held.
  assign LEDR = {sel, {(17-WIDTH){1'b0}}, mux_y};

  // Stage p1: everything shown on LEDG, HEX and debug buses is captured here.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_mux  <= '0;
      sw_p1  <= '0;
      sel_p1 <= 1'b0;
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else begin
      r_mux  <= mux_y;
      sw_p1  <= SW[15:0];
      sel_p1 <= sel;
      hb_cnt <= hb_cnt + HB_BITS'(1);
      // Counter wraps every 2^HB_BITS cycles; flip the LED on the wrap.
      if (&hb_cnt) hb <= ~hb;
    end
  end

  assign mux_byte = 8'(r_mux);

  assign LEDG = {hb, mux_byte};

  assign HEX0 = hex_to_seg(mux_byte[3:0]);
  assign HEX1 = hex_to_seg(mux_byte[7:4]);
  assign HEX2 = hex_to_seg(sw_p1[3:0]);
  assign HEX3 = hex_to_seg(sw_p1[7:4]);
  assign HEX4 = hex_to_seg(sw_p1[11:8]);
  assign HEX5 = hex_to_seg(sw_p1[15:12]);
  assign HEX6 = SEG_BLANK;
  assign HEX7 = SEG_BLANK;

  assign w_d0x0 = sw_p1[7:0];
  assign w_d0x1 = sw_p1[15:8];
  assign w_d0x2 = {7'b0, sel_p1};
  assign w_d0x3 = mux_byte;
  assign w_d0x4 = '0;
  assign w_d0x5 = '0;
  assign w_d1x0 = '0;
  assign w_d1x1 = '0;
  assign w_d1x2 = '0;
  assign w_d1x3 = '0;
  assign w_d1x4 = '0;
  assign w_d1x5 = '0;

  assign UART_TXD = 1'b1;
  assign GPIO_0   = 'z;
  assign GPIO_1   = 'z;

  // Board pins with no function yet; folded together so they stay connected.
  assign unused_inputs = ^{KEY[3:1], CLOCK_27, SW[16], UART_RXD, GPIO_0, GPIO_1};

endmodule

// File: tb/tb_mod_test.sv
module tb_mod_test;

  logic        CLOCK_50;
  logic [3:0]  KEY;
  logic        CLOCK_27;
  logic [17:0] SW;
  logic [0:6]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [8:0]  LEDG;
  logic [17:0] LEDR;
  logic        UART_TXD;
  logic        UART_RXD;
  logic [7:0]  w_d0x0, w_d0x1, w_d0x2, w_d0x3, w_d0x4, w_d0x5;
  logic [7:0]  w_d1x0, w_d1x1, w_d1x2, w_d1x3, w_d1x4, w_d1x5;
  wire  [35:0] GPIO_0;
  wire  [35:0] GPIO_1;

  logic clk_en;
  int   checks;
  int   errors;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001;
  localparam logic [6:0] SE = 7'b0110000;
  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] SBLANK = 7'b1111111;

  mod_test #(.WIDTH(8)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .CLOCK_27 (CLOCK_27),
    .SW       (SW),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .HEX6     (HEX6),
    .HEX7     (HEX7),
    .LEDG     (LEDG),
    .LEDR     (LEDR),
    .UART_TXD (UART_TXD),
    .UART_RXD (UART_RXD),
    .w_d0x0   (w_d0x0),
    .w_d0x1   (w_d0x1),
    .w_d0x2   (w_d0x2),
    .w_d0x3   (w_d0x3),
    .w_d0x4   (w_d0x4),
    .w_d0x5   (w_d0x5),
    .w_d1x0   (w_d1x0),
    .w_d1x1   (w_d1x1),
    .w_d1x2   (w_d1x2),
    .w_d1x3   (w_d1x3),
    .w_d1x4   (w_d1x4),
    .w_d1x5   (w_d1x5),
    .GPIO_0   (GPIO_0),
    .GPIO_1   (GPIO_1)
  );

  // 50 MHz clock, gated so the early steps run with the clock idle.
  always begin
    #10;
    if (clk_en) CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    clk_en   = 1'b0;
    CLOCK_50 = 1'b0;
    CLOCK_27 = 1'b0;
    UART_RXD = 1'b1;
    KEY      = 4'b0000;
    SW       = 18'h0;
    #5;

    // Reset held, clock idle
    check("rst_ledg",   32'(LEDG),   32'h000);
    check("rst_d0x0",   32'(w_d0x0), 32'h00);
    check("rst_d0x3",   32'(w_d0x3), 32'h00);
    check("rst_hex0",   32'(HEX0),   32'(S0));
    check("rst_hex5",   32'(HEX5),   32'(S0));
    check("rst_hex6",   32'(HEX6),   32'(SBLANK));
    check("rst_uart",   32'(UART_TXD), 32'h1);

    // Combinational mux while in reset with no clock
    SW = {1'b0, 1'b0, 8'hF0, 8'h0F};
    #5;
    check("mux_a",      32'(LEDR[7:0]),  32'h0F);
    check("ledr17_0",   32'(LEDR[17]),   32'h0);
    check("ledr_mid",   32'(LEDR[16:8]), 32'h000);

    SW[17] = 1'b1;
    #5;
    check("mux_b",      32'(LEDR[7:0]),  32'hF0);
    check("ledr17_1",   32'(LEDR[17]),   32'h1);

    SW[15:8] = 8'hFA;
    #5;
    check("mux_b_fa",   32'(LEDR[7:0]),  32'hFA);

    SW[7:0] = 8'hBF;
    KEY[1]  = 1'b1;
    #5;
    check("key1_ign",   32'(LEDR[7:0]),  32'hFA);
    check("noclk_ledg", 32'(LEDG),       32'h000);
    check("noclk_hex2", 32'(HEX2),       32'(S0));

    // Release reset, start the clock, select A = 0x3C
    SW     = {1'b0, 1'b0, 8'hFA, 8'h3C};
    KEY[0] = 1'b1;
    #5;
    check("mux_3c",     32'(LEDR[7:0]),  32'h3C);
    check("pre_edge",   32'(LEDG),       32'h000);
    clk_en = 1'b1;
    edge_sample();
    check("ledg_3c",    32'(LEDG[7:0]),  32'h3C);
    check("hb_low",     32'(LEDG[8]),    32'h0);
    check("hex0_c",     32'(HEX0),       32'(SC));
    check("hex1_3",     32'(HEX1),       32'(S3));
    check("hex2_c",     32'(HEX2),       32'(SC));
    check("hex3_3",     32'(HEX3),       32'(S3));
    check("hex4_a",     32'(HEX4),       32'(SA));
    check("hex5_f",     32'(HEX5),       32'(SF));
    check("d0x0",       32'(w_d0x0),     32'h3C);
    check("d0x1",       32'(w_d0x1),     32'hFA);
    check("d0x2_0",     32'(w_d0x2),     32'h00);
    check("d0x3_3c",    32'(w_d0x3),     32'h3C);
    check("d0x4",       32'(w_d0x4),     32'h00);
    check("d1x0",       32'(w_d1x0),     32'h00);
    check("d1x5",       32'(w_d1x5),     32'h00);

    // Select B: LEDR moves now, registered outputs one edge later
    SW[17] = 1'b1;
    #1;
    check("sel_comb",   32'(LEDR[7:0]),  32'hFA);
    check("sel_hold",   32'(LEDG[7:0]),  32'h3C);
    edge_sample();
    check("ledg_fa",    32'(LEDG[7:0]),  32'hFA);
    check("d0x2_1",     32'(w_d0x2),     32'h01);
    check("hex0_a",     32'(HEX0),       32'(SA));
    check("hex1_f",     32'(HEX1),       32'(SF));

    // A = 0x96, B = 0x7E, select A
    SW = {1'b0, 1'b0, 8'h7E, 8'h96};
    edge_sample();
    check("ledg_96",    32'(LEDG[7:0]),  32'h96);
    check("hex0_6",     32'(HEX0),       32'(S6));
    check("hex1_9",     32'(HEX1),       32'(S9));
    check("hex4_e",     32'(HEX4),       32'(SE));
    check("hex5_7",     32'(HEX5),       32'(S7));

    // A = 0x21, B = 0xB4, select B
    SW = {1'b1, 1'b0, 8'hB4, 8'h21};
    edge_sample();
    check("ledg_b4",    32'(LEDG[7:0]),  32'hB4);
    check("hex0_4",     32'(HEX0),       32'(S4));
    check("hex1_b",     32'(HEX1),       32'(SB));
    check("hex2_1",     32'(HEX2),       32'(S1));
    check("hex3_2",     32'(HEX3),       32'(S2));

    // Reassert reset between edges: clears without a clock edge
    @(negedge CLOCK_50);
    KEY[0] = 1'b0;
    #1;
    check("arst_ledg",  32'(LEDG),       32'h000);
    check("arst_d0x0",  32'(w_d0x0),     32'h00);
    check("arst_d0x2",  32'(w_d0x2),     32'h00);
    check("arst_d0x3",  32'(w_d0x3),     32'h00);
    check("arst_hex0",  32'(HEX0),       32'(S0));
    check("arst_hex4",  32'(HEX4),       32'(S0));
    check("arst_ledr",  32'(LEDR[7:0]),  32'hB4);
    edge_sample();
    check("rst_hold",   32'(LEDG),       32'h000);

    // Release mid-cycle: reload on the next rising edge
    @(negedge CLOCK_50);
    KEY[0] = 1'b1;
    #1;
    check("rel_wait",   32'(LEDG),       32'h000);
    edge_sample();
    check("rel_ledg",   32'(LEDG[7:0]),  32'hB4);
    check("rel_d0x3",   32'(w_d0x3),     32'hB4);

    // Constant outputs
    check("uart_idle",  32'(UART_TXD),   32'h1);
    check("hex6_blank", 32'(HEX6),       32'(SBLANK));
    check("hex7_blank", 32'(HEX7),       32'(SBLANK));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_test.md
Name: mod_test

Overview:
- Top-level board wrapper (DE2-style pinout) around a width-parameterised 2:1 multiplexer.
- The mux selects between two 8-bit switch operands: SW[7:0] when SW[17]=0, SW[15:8] when SW[17]=1.
- The result drives LEDR[7:0] combinationally. Registered copies go to the green LEDs, the 7-segment displays and the debug buses.
- First task block of the single-cycle RISC-V lab series. It proves out the pinout and the mux primitive reused later by the datapath.

Parameters:
- WIDTH, 8, data width of each mux operand and of the result.

Ports:
- CLOCK_50  in  1  system clock; all sequential logic runs on it.
- KEY  in  4  push buttons. KEY[0] is the reset: asynchronous, active-low. KEY[3:1] are unused.
- CLOCK_27  in  1  unused, tied off internally.
- SW  in  18  SW[7:0] is operand A, SW[15:8] is operand B, SW[17] is select, SW[16] is unused.
- HEX0..HEX7  out  7 each, indexed [0:6]  active-low segments, bit 0 = segment a.
- LEDG  out  9  registered status.
- LEDR  out  18  mux result and select echo.
- UART_TXD  out  1  serial transmit, held idle.
- UART_RXD  in  1  ignored.
- w_d0x0..w_d0x5  out  8 each  debug display bus, line 0.
- w_d1x0..w_d1x5  out  8 each  debug display bus, line 1.
- GPIO_0, GPIO_1  inout  36 each  not driven (high-Z).

Behaviour:
- Mux datapath (purely combinational, independent of clock and reset):
  - LEDR[7:0] = SW[17] ? SW[15:8] : SW[7:0].
  - Must settle within the same delta/time step; valid even while KEY[0]=0 and while CLOCK_50 is X or not toggling.
- Other LEDR bits (combinational): LEDR[17] = SW[17]; LEDR[16:8] = 0.
- KEY[1..3] have no effect on any output.
- Result register: r_mux (WIDTH bits) captures the mux result on each CLOCK_50 rising edge.
  - Async clear to 0 while KEY[0]=0.
  - Latency: one cycle after SW changes.
- LEDG (registered): LEDG[7:0] = r_mux. LEDG[8] toggles every 2^24 CLOCK_50 cycles (heartbeat counter); counter and LEDG clear to 0 in reset.
- HEX displays (hex-digit decode; 0-9, A-F standard 7-segment, active-low):
  - HEX0 = r_mux[3:0], HEX1 = r_mux[7:4].
  - HEX2/HEX3 = registered SW[3:0]/SW[7:4].
  - HEX4/HEX5 = registered SW[11:8]/SW[15:12].
  - HEX6/HEX7 = blank (all 1s).
  - During reset, all registered sources are 0, so HEX0-HEX5 show "0" (7'b0000001) and HEX6/HEX7 stay blank.
- Debug buses (registered, cleared to 0 in reset):
  - w_d0x0 = SW[7:0], w_d0x1 = SW[15:8], w_d0x2 = {7'b0, SW[17]}, w_d0x3 = r_mux.
  - w_d0x4, w_d0x5 and all w_d1x* = 0.
- UART_TXD = 1 constant (idle). GPIO_0 and GPIO_1 = all 'z.
- Reset deasserted mid-operation: registers reload on the next rising edge. No other state exists.

Decomposition:
- Package mod_test_pkg:
  - Constant SEG_BLANK = 7'b1111111.
  - Function hex_to_seg(logic [3:0]) returning the [0:6] active-low pattern.
  - Heartbeat counter width constant HB_BITS = 24.
- Sub-module mux2x1 #(WIDTH): ports a, b, sel, y, with y = sel ? b : a. Purely combinational; reused later by the RISC-V datapath.

Test Plan:
- KEY[0]=0, clocks idle, SW[7:0]=0x0F, SW[15:8]=0xF0, SW[17]=0, KEY[1]=0 -> LEDR[7:0]=0x0F within 5 ns.
- Same operands, SW[17]=1 -> LEDR[7:0]=0xF0 and LEDR[17]=1.
- SW[15:8]=0xFA, SW[17]=1 -> LEDR[7:0]=0xFA.
- SW[7:0]=0xBF, SW[15:8]=0xFA, SW[17]=1, KEY[1]=1 -> LEDR[7:0]=0xFA (KEY[1] ignored).
- Release KEY[0] with CLOCK_50 running, SW[17]=0, SW[7:0]=0x3C -> after one edge LEDG[7:0]=0x3C, HEX0 shows C, HEX1 shows 3, w_d0x3=0x3C. Reassert KEY[0] -> LEDG, w_d* go to 0 immediately, without waiting for a clock edge.
- Any time -> UART_TXD=1, HEX6/HEX7=7'b1111111, GPIO_0/GPIO_1 not driven.
